// File: rtl/inst_encoder_loader_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | inst_encoder_loader_pkg: shared widths, opcodes, field placement |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package inst_encoder_loader_pkg;

  localparam int INST_LEN      = 32;
  localparam int INST_SIZE_LOG = 4;
  localparam int REG_LEN       = 16;
  localparam int MEMI_SIZE_LOG = 6;
  localparam int RF_SIZE_LOG   = 4;

  // Field placement must match the core's decode slices exactly.
  localparam int OPCODE_LSB = 28;
  localparam int RD_LSB     = 24;
  localparam int RS1_LSB    = 8;
  localparam int RS2_LSB    = 0;

  typedef enum logic [INST_SIZE_LOG-1:0] {
    OP_LI  = 4'd0,
    OP_ADD = 4'd1,
    OP_MUL = 4'd2,
    OP_LD  = 4'd3,
    OP_BR  = 4'd4
  } opcode_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [MEMI_SIZE_LOG-1:0] PTR_MAX = '1;

  function automatic logic [INST_LEN-1:0] fld_opcode(input logic [INST_SIZE_LOG-1:0] v);
    return INST_LEN'(v) << OPCODE_LSB;
  endfunction

  function automatic logic [INST_LEN-1:0] fld_rd(input logic [RF_SIZE_LOG-1:0] v);
    return INST_LEN'(v) << RD_LSB;
  endfunction

  function automatic logic [INST_LEN-1:0] fld_rs1(input logic [REG_LEN-1:0] v);
    return INST_LEN'(v) << RS1_LSB;
  endfunction

  function automatic logic [INST_LEN-1:0] fld_rs2(input logic [RF_SIZE_LOG-1:0] v);
    return INST_LEN'(v) << RS2_LSB;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_encoder_loader_inst_encode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | inst_encode: packs request fields into a canonical instruction   |
// | word and flags illegal opcodes / out-of-range operands.          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module inst_encode
  import inst_encoder_loader_pkg::*;
(
  input  logic [INST_SIZE_LOG-1:0] opcode,
  input  logic [RF_SIZE_LOG-1:0]   rd,
  input  logic [REG_LEN-1:0]       rs1_imm,
  input  logic [RF_SIZE_LOG-1:0]   rs2,
  output logic [INST_LEN-1:0]      word,
  output logic                     legal
);

  logic w_rs1_fits;
  logic w_off_fits;

  assign w_rs1_fits = (rs1_imm[REG_LEN-1:RF_SIZE_LOG] == '0);
  assign w_off_fits = (rs1_imm[REG_LEN-1:MEMI_SIZE_LOG] == '0);

  // Fields an opcode does not use stay zero so each instruction has one encoding.
  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (opcode)
      OP_LI: begin
        word  = fld_opcode(opcode) | fld_rd(rd) | fld_rs1(rs1_imm);
        legal = 1'b1;
      end
      OP_ADD, OP_MUL: begin
        word  = fld_opcode(opcode) | fld_rd(rd)
              | fld_rs1(REG_LEN'(rs1_imm[RF_SIZE_LOG-1:0])) | fld_rs2(rs2);
        legal = w_rs1_fits;
      end
      OP_LD: begin
        word  = fld_opcode(opcode) | fld_rd(rd)
              | fld_rs1(REG_LEN'(rs1_imm[RF_SIZE_LOG-1:0]));
        legal = w_rs1_fits;
      end
      OP_BR: begin
        word  = fld_opcode(opcode)
              | fld_rs1(REG_LEN'(rs1_imm[MEMI_SIZE_LOG-1:0])) | fld_rs2(rs2);
        legal = w_off_fits;
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/inst_encoder_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | inst_encoder_loader: accepts instruction requests and writes the |
// | encoded words into consecutive instruction-memory slots.         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module inst_encoder_loader
  import inst_encoder_loader_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [MEMI_SIZE_LOG-1:0] start_base,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [INST_SIZE_LOG-1:0] req_opcode,
  input  logic [RF_SIZE_LOG-1:0]   req_rd,
  input  logic [REG_LEN-1:0]       req_rs1_imm,
  input  logic [RF_SIZE_LOG-1:0]   req_rs2,
  input  logic                     req_last,
  output logic                     imem_wen,
  output logic [MEMI_SIZE_LOG-1:0] imem_waddr,
  output logic [INST_LEN-1:0]      imem_wdata,
  output logic [MEMI_SIZE_LOG:0]   count,
  output logic                     done,
  output logic                     err
);

  logic [1:0]               r_state;
  logic [1:0]               w_state_next;
  logic [MEMI_SIZE_LOG-1:0] r_ptr;
  logic [MEMI_SIZE_LOG:0]   r_count;
  logic                     r_done;
  logic                     r_err;
  logic                     r_wen;
  logic [MEMI_SIZE_LOG-1:0] r_waddr;
  logic [INST_LEN-1:0]      r_wdata;

  logic                     w_ready;
  logic                     w_accept;
  logic                     w_init;
  logic                     w_legal;
  logic [INST_LEN-1:0]      w_word;

  inst_encode u_encode (
    .opcode  (req_opcode),
    .rd      (req_rd),
    .rs1_imm (req_rs1_imm),
    .rs2     (req_rs2),
    .word    (w_word),
    .legal   (w_legal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A legal last request ends cleanly even at the top slot, since its write fits.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_LOAD: begin
        if (w_accept) begin
          if (!w_legal) begin
            w_state_next = ST_ERR;
          end else if (req_last) begin
            w_state_next = ST_DONE;
          end else if (r_ptr == PTR_MAX) begin
            w_state_next = ST_ERR;
          end
        end
      end
      default: begin
        if (start) begin
          w_state_next = ST_LOAD;
        end
      end
    endcase
  end

  always_comb begin
    w_ready  = (r_state == ST_LOAD);
    w_accept = req_valid & w_ready;
    w_init   = start & ~w_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_wen <= 1'b0;
      if (w_init) begin
        r_ptr   <= start_base;
        r_count <= '0;
        r_done  <= 1'b0;
        r_err   <= 1'b0;
      end else if (w_accept) begin
        if (w_legal) begin
          r_wen   <= 1'b1;
          r_waddr <= r_ptr;
          r_wdata <= w_word;
          r_ptr   <= r_ptr + 1'b1;
          r_count <= r_count + 1'b1;
          if (req_last) begin
            r_done <= 1'b1;
          end else if (r_ptr == PTR_MAX) begin
            r_err <= 1'b1;
          end
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign req_ready  = w_ready;
  assign imem_wen   = r_wen;
  assign imem_waddr = r_waddr;
  assign imem_wdata = r_wdata;
  assign count      = r_count;
  assign done       = r_done;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_inst_encoder_loader: directed + random bench with a field-    |
// | level reference model of the loader session.                     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_inst_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  start_base = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_opcode = '0;
  logic [3:0]  req_rd = '0;
  logic [15:0] req_rs1_imm = '0;
  logic [3:0]  req_rs2 = '0;
  logic        req_last = 1'b0;
  logic        imem_wen;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [6:0]  count;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  // Reference model: session flags, slot pointer and expected write log.
  bit          m_active = 0;
  bit          m_done   = 0;
  bit          m_err    = 0;
  int          m_ptr    = 0;
  int          m_count  = 0;
  logic [37:0] exp_q[$];
  logic [37:0] obs_q[$];

  inst_encoder_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_base  (start_base),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_opcode  (req_opcode),
    .req_rd      (req_rd),
    .req_rs1_imm (req_rs1_imm),
    .req_rs2     (req_rs2),
    .req_last    (req_last),
    .imem_wen    (imem_wen),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .count       (count),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_wen === 1'b1) obs_q.push_back({imem_waddr, imem_wdata});
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal_m(input int op, input int imm);
    case (op)
      0:       return 1'b1;
      1, 2, 3: return imm < 16;
      4:       return imm < 64;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] enc_m(input int op, input int rd, input int imm, input int rs2);
    int f_rd;
    int f_rs2;
    f_rd  = (op == 4) ? 0 : rd;
    f_rs2 = (op == 0 || op == 3) ? 0 : rs2;
    return 32'((op << 28) | (f_rd << 24) | (imm << 8) | f_rs2);
  endfunction

  // Decode-side view: fields an opcode ignores must read back as zero.
  function automatic bit canon_ok(input logic [31:0] w);
    int op;
    op = int'(w[31:28]);
    if (w[7:4] != 4'd0) return 1'b0;
    if (op == 4 && w[27:24] != 4'd0) return 1'b0;
    if ((op == 0 || op == 3) && w[3:0] != 4'd0) return 1'b0;
    if ((op >= 1 && op <= 3) && w[23:12] != 12'd0) return 1'b0;
    if (op == 4 && w[23:14] != 10'd0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_status(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(m_count));
    chk({tag, ".done"},  32'(done),  32'(m_done));
    chk({tag, ".err"},   32'(err),   32'(m_err));
    chk({tag, ".ready"}, 32'(req_ready), 32'(m_active));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    m_active = 0; m_done = 0; m_err = 0; m_count = 0;
    chk("rst.wen",   32'(imem_wen),   0);
    chk("rst.waddr", 32'(imem_waddr), 0);
    chk("rst.wdata", imem_wdata,      0);
    check_status("rst");
    rst_n = 1'b1;
  endtask

  task automatic do_start(input int base);
    start_base = 6'(base);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (!m_active) begin
      m_active = 1; m_ptr = base; m_count = 0; m_done = 0; m_err = 0;
    end
    check_status("start");
  endtask

  task automatic send(input int op, input int rd, input int imm, input int rs2,
                      input bit last, input int gap);
    bit          exp_wen;
    logic [31:0] exp_data;
    int          exp_addr;
    req_opcode = 4'(op); req_rd = 4'(rd); req_rs1_imm = 16'(imm);
    req_rs2 = 4'(rs2); req_last = last; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_wen = 0; exp_addr = 0; exp_data = '0;
    if (m_active) begin
      if (legal_m(op, imm)) begin
        exp_wen = 1; exp_addr = m_ptr; exp_data = enc_m(op, rd, imm, rs2);
        exp_q.push_back({6'(exp_addr), exp_data});
        m_count++;
        if (last) begin
          m_active = 0; m_done = 1;
        end else if (m_ptr == 63) begin
          m_active = 0; m_err = 1;
        end
        m_ptr = (m_ptr + 1) % 64;
      end else begin
        m_active = 0; m_err = 1;
      end
    end
    chk("req.wen", 32'(imem_wen), 32'(exp_wen));
    if (exp_wen) begin
      chk("req.waddr", 32'(imem_waddr), 32'(exp_addr));
      chk("req.wdata", imem_wdata, exp_data);
      chk("req.canon", 32'(canon_ok(imem_wdata)), 1);
    end
    check_status("req");
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      chk("gap.wen", 32'(imem_wen), 0);
    end
  endtask

  initial begin
    int op;
    int imm;
    int n;
    do_reset();

    do_start(4);
    send(0, 1, 7, 0, 0, 0);
    send(1, 2, 1, 1, 0, 0);
    send(4, 0, 2, 2, 1, 0);
    chk("basic.count", 32'(count), 3);
    chk("basic.done", 32'(done), 1);

    do_start(10);
    send(3, 3, 2, 15, 1, 1);

    do_start(20);
    send(0, 5, 100, 0, 0, 0);
    send(9, 1, 1, 1, 0, 0);
    chk("illegal.err", 32'(err), 1);
    send(0, 1, 1, 0, 0, 0);
    do_start(20);
    send(1, 1, 16, 1, 0, 0);

    do_start(63);
    send(1, 1, 2, 3, 0, 0);
    send(0, 2, 5, 0, 0, 0);
    do_start(63);
    send(1, 1, 2, 3, 1, 0);
    send(0, 2, 5, 0, 0, 0);

    do_start(30);
    send(0, 1, 1, 0, 0, 0);
    do_start(40);
    send(2, 4, 3, 5, 0, 0);
    send(4, 0, 64, 1, 0, 0);

    do_start(45);
    for (int k = 0; k < 5; k++) begin
      send(k % 5, k + 1, k, k + 2, k == 4, (k % 2 == 0) ? 2 : 0);
    end

    for (int s = 0; s < 6; s++) begin
      do_start(int'($urandom_range(0, 40)));
      n = int'($urandom_range(3, 12));
      for (int k = 0; k < n && m_active; k++) begin
        op = int'($urandom_range(0, 4));
        imm = (op == 0) ? int'($urandom_range(0, 65535)) :
              (op == 4) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 15));
        if ($urandom_range(0, 9) == 0) begin
          if ($urandom_range(0, 1) == 0) op = int'($urandom_range(5, 15));
          else imm = int'($urandom_range(64, 65535));
        end
        send(op, int'($urandom_range(0, 15)), imm, int'($urandom_range(0, 15)),
             k == n - 1, int'($urandom_range(0, 2)));
      end
    end

    do_start(12);
    send(0, 1, 9, 0, 0, 0);
    send(1, 2, 3, 4, 0, 0);
    do_reset();
    do_start(33);
    send(2, 6, 7, 8, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("log.size", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk("log.addr", 32'(obs_q[i][37:32]), 32'(exp_q[i][37:32]));
      chk("log.data", obs_q[i][31:0], exp_q[i][31:0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
